// File: rtl/punc_control.sv
// punc_control: multi-cycle LC3 control FSM sequencing fetch/decode/execute for the PUnC datapath
//   clk, rst (async, active-low)          ir, n/z/p from datapath
//   ir_ld, pc_ld, pc_sel, mem_addr_sel, mem_w_en, rf_r0_addr, rf_r1_addr,
//   rf_w_en, rf_w_addr, rf_w_sel, alu_op, alu_b_imm, cc_ld, temp_ld, halted
module punc_control #(
  parameter logic [7:0] HALT_VECT = 8'h25,
  parameter bit         HALT_ANY  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic [2:0]  rf_r0_addr,
  output logic [2:0]  rf_r1_addr,
  output logic        rf_w_en,
  output logic [2:0]  rf_w_addr,
  output logic [1:0]  rf_w_sel,
  output logic [1:0]  alu_op,
  output logic        alu_b_imm,
  output logic        cc_ld,
  output logic        temp_ld,
  output logic        halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, EXEC2, HALT} state_t;
  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                         OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                         OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                         OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_LEA = 4'b1110, OP_TRAP = 4'b1111;
  state_t state, nxt;
  logic [3:0] op;
  logic halt_trap, br_taken, is_store;
  assign op        = ir[15:12];
  assign halt_trap = (op == OP_TRAP) && (HALT_ANY || ir[7:0] == HALT_VECT);
  assign br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign is_store  = (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FETCH;
    else      state <= nxt;
  // Every output is forced to 0 while reset is asserted, so an aborted
  // instruction can never leave a write enable high.
  always_comb begin
    nxt          = state;
    ir_ld        = 1'b0;
    pc_ld        = 1'b0;
    pc_sel       = 2'd0;
    mem_addr_sel = 2'd0;
    mem_w_en     = 1'b0;
    rf_r0_addr   = 3'd0;
    rf_r1_addr   = 3'd0;
    rf_w_en      = 1'b0;
    rf_w_addr    = 3'd0;
    rf_w_sel     = 2'd0;
    alu_op       = 2'd0;
    alu_b_imm    = 1'b0;
    cc_ld        = 1'b0;
    temp_ld      = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      rf_r0_addr = ir[8:6];
      rf_r1_addr = is_store ? ir[11:9] : ir[2:0];
      rf_w_addr  = (op == OP_JSR) ? 3'd7 : ir[11:9];
      case (state)
        FETCH: begin
          ir_ld = 1'b1;
          pc_ld = 1'b1;
          nxt   = DECODE;
        end
        DECODE: nxt = halt_trap ? HALT : EXEC;
        EXEC: begin
          nxt = FETCH;
          case (op)
            OP_ADD, OP_AND: begin
              rf_w_en   = 1'b1;
              cc_ld     = 1'b1;
              alu_b_imm = ir[5];
              alu_op    = (op == OP_AND) ? 2'd1 : 2'd0;
            end
            OP_NOT: begin
              alu_op  = 2'd2;
              rf_w_en = 1'b1;
              cc_ld   = 1'b1;
            end
            OP_LD, OP_LDR: begin
              mem_addr_sel = (op == OP_LD) ? 2'd1 : 2'd2;
              rf_w_sel     = 2'd1;
              rf_w_en      = 1'b1;
              cc_ld        = 1'b1;
            end
            OP_LEA: begin
              rf_w_sel = 2'd2;
              rf_w_en  = 1'b1;
              cc_ld    = 1'b1;
            end
            OP_ST, OP_STR: begin
              mem_addr_sel = (op == OP_ST) ? 2'd1 : 2'd2;
              mem_w_en     = 1'b1;
            end
            OP_LDI, OP_STI: begin
              mem_addr_sel = 2'd1;
              temp_ld      = 1'b1;
              nxt          = EXEC2;
            end
            OP_BR: begin
              pc_ld  = br_taken;
              pc_sel = br_taken ? 2'd1 : 2'd0;
            end
            OP_JMP: begin
              pc_ld  = 1'b1;
              pc_sel = 2'd3;
            end
            // Link and jump share the cycle: JSRR R7 reads the old R7 as its
            // target because the register read precedes the write edge.
            OP_JSR: begin
              rf_w_sel = 2'd3;
              rf_w_en  = 1'b1;
              pc_ld    = 1'b1;
              pc_sel   = ir[11] ? 2'd2 : 2'd3;
            end
            default: ;
          endcase
        end
        EXEC2: begin
          nxt          = FETCH;
          mem_addr_sel = 2'd3;
          if (op == OP_LDI) begin
            rf_w_sel = 2'd1;
            rf_w_en  = 1'b1;
            cc_ld    = 1'b1;
          end
          mem_w_en = (op == OP_STI);
        end
        HALT: halted = 1'b1;
        default: nxt = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_punc_control.sv
// tb_punc_control: directed self-checking bench for punc_control
module tb_punc_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] ir = 16'h0;
  logic n = 1'b0, z = 1'b0, p = 1'b0;
  logic ir_ld, pc_ld, mem_w_en, rf_w_en, alu_b_imm, cc_ld, temp_ld, halted;
  logic [1:0] pc_sel, mem_addr_sel, rf_w_sel, alu_op;
  logic [2:0] rf_r0_addr, rf_r1_addr, rf_w_addr;
  logic ir_ld0, pc_ld0, mem_w_en0, rf_w_en0, alu_b_imm0, cc_ld0, temp_ld0, halted0;
  logic [1:0] pc_sel0, mem_addr_sel0, rf_w_sel0, alu_op0;
  logic [2:0] rf_r0_addr0, rf_r1_addr0, rf_w_addr0;
  logic [6:0] en, en0;
  int checks = 0, errs = 0;
  assign en  = {ir_ld, pc_ld, mem_w_en, rf_w_en, cc_ld, temp_ld, halted};
  assign en0 = {ir_ld0, pc_ld0, mem_w_en0, rf_w_en0, cc_ld0, temp_ld0, halted0};
  always #5 clk = ~clk;
  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_sel(pc_sel), .mem_addr_sel(mem_addr_sel),
    .mem_w_en(mem_w_en), .rf_r0_addr(rf_r0_addr), .rf_r1_addr(rf_r1_addr),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_sel(rf_w_sel), .alu_op(alu_op),
    .alu_b_imm(alu_b_imm), .cc_ld(cc_ld), .temp_ld(temp_ld), .halted(halted)
  );
  punc_control #(.HALT_ANY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .ir_ld(ir_ld0), .pc_ld(pc_ld0), .pc_sel(pc_sel0), .mem_addr_sel(mem_addr_sel0),
    .mem_w_en(mem_w_en0), .rf_r0_addr(rf_r0_addr0), .rf_r1_addr(rf_r1_addr0),
    .rf_w_en(rf_w_en0), .rf_w_addr(rf_w_addr0), .rf_w_sel(rf_w_sel0), .alu_op(alu_op0),
    .alu_b_imm(alu_b_imm0), .cc_ld(cc_ld0), .temp_ld(temp_ld0), .halted(halted0)
  );
  task automatic step;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    ir = 16'h127F;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({en, pc_sel, mem_addr_sel, rf_r0_addr, rf_r1_addr, rf_w_addr, rf_w_sel, alu_op, alu_b_imm} !== 0) begin
      errs++;
      $display("FAIL reset_outputs_zero: en=%b rf_w_addr=%0d rf_r0=%0d expected all zero", en, rf_w_addr, rf_r0_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (en !== 7'b1100000 || pc_sel !== 2'd0 || mem_addr_sel !== 2'd0) begin
      errs++;
      $display("FAIL reset_fetch: en=%b pc_sel=%0d mas=%0d expected en=1100000 pc_sel=0 mas=0", en, pc_sel, mem_addr_sel);
    end
  endtask
  task automatic test_reset_mid_st;
    ir = 16'h3605;
    do_reset();
    step();
    step();
    checks++;
    if (en !== 7'b0010000 || mem_addr_sel !== 2'd1 || rf_r1_addr !== 3'd3) begin
      errs++;
      $display("FAIL st_exec: en=%b mas=%0d r1=%0d expected en=0010000 mas=1 r1=3", en, mem_addr_sel, rf_r1_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_w_en !== 1'b0 || rf_w_en !== 1'b0) begin
      errs++;
      $display("FAIL st_abort: mem_w_en=%b rf_w_en=%b expected 0 0", mem_w_en, rf_w_en);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (en !== 7'b1100000) begin
      errs++;
      $display("FAIL st_after_release: en=%b expected 1100000", en);
    end
  endtask
  task automatic test_add;
    ir = 16'h127F;
    do_reset();
    step();
    checks++;
    if (en !== 7'b0000000) begin
      errs++;
      $display("FAIL add_decode: en=%b expected 0000000", en);
    end
    step();
    checks++;
    if (en !== 7'b0001100 || alu_b_imm !== 1'b1 || rf_w_addr !== 3'd1 || rf_w_sel !== 2'd0 ||
        alu_op !== 2'd0 || rf_r0_addr !== 3'd1) begin
      errs++;
      $display("FAIL add_exec: en=%b imm=%b wa=%0d ws=%0d op=%0d r0=%0d expected 0001100 1 1 0 0 1",
               en, alu_b_imm, rf_w_addr, rf_w_sel, alu_op, rf_r0_addr);
    end
    ir = 16'h5A82;
    #1;
    checks++;
    if (alu_op !== 2'd1 || alu_b_imm !== 1'b0 || rf_r1_addr !== 3'd2 || rf_w_addr !== 3'd5) begin
      errs++;
      $display("FAIL and_reg_exec: op=%0d imm=%b r1=%0d wa=%0d expected 1 0 2 5", alu_op, alu_b_imm, rf_r1_addr, rf_w_addr);
    end
    step();
    checks++;
    if (en !== 7'b1100000) begin
      errs++;
      $display("FAIL add_back_to_fetch: en=%b expected 1100000", en);
    end
  endtask
  task automatic test_branch;
    ir = 16'h0405;
    {n, z, p} = 3'b010;
    do_reset();
    step();
    step();
    checks++;
    if (pc_ld !== 1'b1 || pc_sel !== 2'd1) begin
      errs++;
      $display("FAIL brz_taken: pc_ld=%b pc_sel=%0d expected 1 1", pc_ld, pc_sel);
    end
    {n, z, p} = 3'b100;
    #1;
    checks++;
    if (pc_ld !== 1'b0) begin
      errs++;
      $display("FAIL brz_not_taken: pc_ld=%b expected 0", pc_ld);
    end
    ir = 16'h0005;
    {n, z, p} = 3'b111;
    #1;
    checks++;
    if (pc_ld !== 1'b0) begin
      errs++;
      $display("FAIL br_nzp000: pc_ld=%b expected 0", pc_ld);
    end
    {n, z, p} = 3'b000;
  endtask
  task automatic test_store_load;
    ir = 16'h7683;
    do_reset();
    step();
    step();
    checks++;
    if (en !== 7'b0010000 || mem_addr_sel !== 2'd2 || rf_r0_addr !== 3'd2 || rf_r1_addr !== 3'd3) begin
      errs++;
      $display("FAIL str_exec: en=%b mas=%0d r0=%0d r1=%0d expected 0010000 2 2 3", en, mem_addr_sel, rf_r0_addr, rf_r1_addr);
    end
    ir = 16'h6A41;
    #1;
    checks++;
    if (en !== 7'b0001100 || mem_addr_sel !== 2'd2 || rf_w_sel !== 2'd1) begin
      errs++;
      $display("FAIL ldr_exec: en=%b mas=%0d ws=%0d expected 0001100 2 1", en, mem_addr_sel, rf_w_sel);
    end
    ir = 16'hE60F;
    #1;
    checks++;
    if (en !== 7'b0001100 || rf_w_sel !== 2'd2 || rf_w_addr !== 3'd3) begin
      errs++;
      $display("FAIL lea_exec: en=%b ws=%0d wa=%0d expected 0001100 2 3", en, rf_w_sel, rf_w_addr);
    end
    ir = 16'h987F;
    #1;
    checks++;
    if (en !== 7'b0001100 || alu_op !== 2'd2) begin
      errs++;
      $display("FAIL not_exec: en=%b op=%0d expected 0001100 2", en, alu_op);
    end
  endtask
  task automatic test_ldi;
    ir = 16'hA402;
    do_reset();
    step();
    step();
    checks++;
    if (en !== 7'b0000010 || mem_addr_sel !== 2'd1) begin
      errs++;
      $display("FAIL ldi_exec: en=%b mas=%0d expected 0000010 1", en, mem_addr_sel);
    end
    step();
    checks++;
    if (en !== 7'b0001100 || mem_addr_sel !== 2'd3 || rf_w_addr !== 3'd2 || rf_w_sel !== 2'd1) begin
      errs++;
      $display("FAIL ldi_exec2: en=%b mas=%0d wa=%0d ws=%0d expected 0001100 3 2 1", en, mem_addr_sel, rf_w_addr, rf_w_sel);
    end
    step();
    checks++;
    if (en !== 7'b1100000) begin
      errs++;
      $display("FAIL ldi_4cycle_fetch: en=%b expected 1100000", en);
    end
    ir = 16'hB602;
    step();
    step();
    step();
    checks++;
    if (en !== 7'b0010000 || mem_addr_sel !== 2'd3 || rf_r1_addr !== 3'd3) begin
      errs++;
      $display("FAIL sti_exec2: en=%b mas=%0d r1=%0d expected 0010000 3 3", en, mem_addr_sel, rf_r1_addr);
    end
  endtask
  task automatic test_jsr;
    ir = 16'h41C0;
    do_reset();
    step();
    step();
    checks++;
    if (en !== 7'b0101000 || rf_w_addr !== 3'd7 || rf_w_sel !== 2'd3 || pc_sel !== 2'd3 || rf_r0_addr !== 3'd7) begin
      errs++;
      $display("FAIL jsrr_exec: en=%b wa=%0d ws=%0d ps=%0d r0=%0d expected 0101000 7 3 3 7",
               en, rf_w_addr, rf_w_sel, pc_sel, rf_r0_addr);
    end
    ir = 16'h4805;
    #1;
    checks++;
    if (pc_sel !== 2'd2 || rf_w_addr !== 3'd7) begin
      errs++;
      $display("FAIL jsr_exec: ps=%0d wa=%0d expected 2 7", pc_sel, rf_w_addr);
    end
    ir = 16'hC080;
    #1;
    checks++;
    if (en !== 7'b0100000 || pc_sel !== 2'd3 || rf_r0_addr !== 3'd2) begin
      errs++;
      $display("FAIL jmp_exec: en=%b ps=%0d r0=%0d expected 0100000 3 2", en, pc_sel, rf_r0_addr);
    end
  endtask
  task automatic test_halt;
    ir = 16'hF025;
    do_reset();
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (en !== 7'b0000001 || en0 !== 7'b0000001) begin
        errs++;
        $display("FAIL halt_hold cycle %0d: en=%b en0=%b expected 0000001", i, en, en0);
      end
    end
    ir = 16'hF021;
    do_reset();
    step();
    step();
    checks++;
    if (en !== 7'b0000001 || en0 !== 7'b0000000) begin
      errs++;
      $display("FAIL trap21_exec: en=%b en0=%b expected 0000001 0000000", en, en0);
    end
    step();
    checks++;
    if (en0 !== 7'b1100000 || en !== 7'b0000001) begin
      errs++;
      $display("FAIL trap21_noop_fetch: en0=%b en=%b expected 1100000 0000001", en0, en);
    end
  endtask
  initial begin
    test_reset();
    test_reset_mid_st();
    test_add();
    test_branch();
    test_store_load();
    test_ldi();
    test_jsr();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
